// File: rtl/demorgan_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// demorgan_sweep_ctrl
//   Self-test sequencer for the demorgan datapath. On start it drives the four
//   input vectors {A,B} = 00,01,10,11 into one demorgan instance. It holds each
//   vector for SETTLE_CYCLES cycles and then checks all six datapath outputs.
//   The sweep result is reported as a pass flag, a per-vector failure mask and
//   a failing-vector count.
//
// Parameters
//   SETTLE_CYCLES  cycles A/B are held before the outputs are checked (0 -> 1)
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous, active-high reset
//   start      in   begin a sweep; sampled only in IDLE
//   A, B       out  registered datapath inputs
//   nA, nB, n_AandB, nAornB, n_AorB, nAandnB
//              in   datapath outputs under test
//   busy       out  high while settling or checking
//   done       out  one-cycle pulse at end of sweep
//   pass       out  1 = no failing vector; valid from done until next start
//   fail_mask  out  bit i set = vector {A,B}=i failed
//   err_count  out  number of failing vectors (0..4)
//
// Build option
//   DEMORGAN_SWEEP_STOP_ON_FAIL_EN : when defined, the first failing vector
//   ends the sweep immediately, with A/B holding that vector.
// -----------------------------------------------------------------------------
module demorgan_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       nA,
  input  logic       nB,
  input  logic       n_AandB,
  input  logic       nAornB,
  input  logic       n_AorB,
  input  logic       nAandnB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_EFF - 1);

`ifdef DEMORGAN_SWEEP_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             pass_q, pass_d;
  logic [3:0]       mask_q, mask_d;
  logic [2:0]       err_q, err_d;

  logic             vec_fail;
  logic [3:0]       mask_upd;
  logic [2:0]       err_upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'd0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    err_d   = err_q;

    // Case-inequality so that X/Z from the datapath counts as a mismatch.
    // nAornB and nAandnB are the De Morgan forms of n_AandB and n_AorB.
    vec_fail = (nA      !== ~a_q)          ||
               (nB      !== ~b_q)          ||
               (n_AandB !== ~(a_q & b_q))  ||
               (nAornB  !== ~(a_q & b_q))  ||
               (n_AorB  !== ~(a_q | b_q))  ||
               (nAandnB !== ~(a_q | b_q));
    mask_upd = mask_q | (vec_fail ? (4'b0001 << vec_q) : 4'b0000);
    err_upd  = (vec_fail && (err_q != 3'd4)) ? err_q + 3'd1 : err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          mask_d  = 4'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CHECK: begin
        mask_d = mask_upd;
        err_d  = err_upd;
        if ((vec_q == 2'd3) || (STOP_ON_FAIL && vec_fail)) begin
          // pass is registered here so it is already valid in the done cycle
          pass_d  = (err_upd == 3'd0);
          state_d = DONE;
        end else begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          cnt_d      = CNT_RELOAD;
          state_d    = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign err_count = err_q;

endmodule
